// File: rtl/enc_pkg.sv
// Shared types and constants for the Hamming(16,11) encode sequencer.
package enc_pkg;
    localparam int MSG_BITS = 11;
    localparam int CW_BITS  = 16;

    typedef logic [CW_BITS-1:0] cw_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_ENC,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } state_t;
endpackage

// File: rtl/hamming16_enc.sv
// Combinational Hamming(16,11) encoder: SEC parity at bits 1,2,4,8 plus overall parity at bit 0.
module hamming16_enc
    import enc_pkg::*;
(
    input  logic [MSG_BITS-1:0] d,
    output cw_t                 cw
);
    logic        w_p8;
    logic        w_p4;
    logic        w_p2;
    logic        w_p1;
    logic [14:0] w_upper;

    assign w_p8 = ^d[10:4];
    assign w_p4 = (^d[10:7]) ^ (^d[3:1]);
    assign w_p2 = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    assign w_p1 = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];

    assign w_upper = {d[10:4], w_p8, d[3:1], w_p4, d[0], w_p2, w_p1};
    assign cw      = {w_upper, ^w_upper};
endmodule

// File: rtl/hamming_enc_sequencer.sv
// Reads WORDS message words as byte pairs, encodes each, and writes codewords back as byte pairs.
// state    | meaning
// IDLE     | waiting for start after reset
// RD_LO    | fetching message low byte
// RD_HI    | fetching message high byte
// ENC      | registering the codeword
// WR_LO    | writing codeword low byte
// WR_HI    | writing codeword high byte, advancing index
// DONE     | run complete, waiting for start
module hamming_enc_sequencer
    import enc_pkg::*;
#(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int WORDS    = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         mem_req,
    input  logic         mem_gnt,
    output logic [A-1:0] mem_raddr,
    input  logic [W-1:0] mem_rdata,
    output logic         mem_we,
    output logic [A-1:0] mem_waddr,
    output logic [W-1:0] mem_wdata
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [MSG_BITS-1:0] r_msg;
    cw_t                 r_cw;
    logic                r_done;

    cw_t                 w_cw;
    logic [A-1:0]        w_off;
    logic [A-1:0]        w_src;
    logic [A-1:0]        w_dst;

    hamming16_enc u_enc (
        .d  (r_msg),
        .cw (w_cw)
    );

    // Addresses wrap modulo 2^A by construction of the A-bit sums.
    assign w_off = A'({r_idx, 1'b0});
    assign w_src = A'(SRC_BASE) + w_off;
    assign w_dst = A'(DST_BASE) + w_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_msg   <= '0;
            r_cw    <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RD_LO;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                    end else if (r_state == ST_DONE) begin
                        r_done  <= 1'b1;
                    end
                end
                ST_RD_LO: begin
                    if (mem_gnt) begin
                        r_msg[7:0] <= mem_rdata[7:0];
                        r_state    <= ST_RD_HI;
                    end
                end
                ST_RD_HI: begin
                    if (mem_gnt) begin
                        r_msg[10:8] <= mem_rdata[2:0];
                        r_state     <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    r_cw    <= w_cw;
                    r_state <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    if (mem_gnt) r_state <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    if (mem_gnt) begin
                        if (r_idx == IW'(WORDS - 1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_state <= ST_RD_LO;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_raddr = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (r_state)
            ST_RD_LO: begin
                mem_req   = 1'b1;
                mem_raddr = w_src;
            end
            ST_RD_HI: begin
                mem_req   = 1'b1;
                mem_raddr = w_src + A'(1);
            end
            ST_WR_LO: begin
                mem_req   = 1'b1;
                mem_we    = mem_gnt;
                mem_waddr = w_dst;
                mem_wdata = W'(r_cw[7:0]);
            end
            ST_WR_HI: begin
                mem_req   = 1'b1;
                mem_we    = mem_gnt;
                mem_waddr = w_dst + A'(1);
                mem_wdata = W'(r_cw[15:8]);
            end
            default: ;
        endcase
    end

    assign busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done = r_done;
endmodule

// File: tb/tb_hamming_enc_sequencer.sv
// Directed bench: single-word vectors on a WORDS=1 instance, full/contention/reset runs on a WORDS=15 instance.
module tb_hamming_enc_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // instance A: WORDS=1
    logic       a_start, a_busy, a_done, a_req, a_gnt, a_we, a_load;
    logic [7:0] a_raddr, a_rdata, a_waddr, a_wdata;
    logic [7:0] a_mem  [0:255];
    logic [7:0] a_init [0:255];

    // instance B: WORDS=15
    logic       b_start, b_busy, b_done, b_req, b_gnt, b_we, b_load;
    logic [7:0] b_raddr, b_rdata, b_waddr, b_wdata;
    logic [7:0] b_mem  [0:255];
    logic [7:0] b_init [0:255];
    int         b_we_cnt = 0;

    hamming_enc_sequencer #(.W(8), .A(8), .WORDS(1), .SRC_BASE(0), .DST_BASE(30)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_req(a_req), .mem_gnt(a_gnt), .mem_raddr(a_raddr), .mem_rdata(a_rdata),
        .mem_we(a_we), .mem_waddr(a_waddr), .mem_wdata(a_wdata)
    );

    hamming_enc_sequencer #(.W(8), .A(8), .WORDS(15), .SRC_BASE(0), .DST_BASE(30)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_req(b_req), .mem_gnt(b_gnt), .mem_raddr(b_raddr), .mem_rdata(b_rdata),
        .mem_we(b_we), .mem_waddr(b_waddr), .mem_wdata(b_wdata)
    );

    assign a_rdata = a_mem[a_raddr];
    assign b_rdata = b_mem[b_raddr];

    always @(posedge clk) begin
        if (a_load) a_mem <= a_init;
        else if (a_we) a_mem[a_waddr] <= a_wdata;
    end

    always @(posedge clk) begin
        if (b_load) b_mem <= b_init;
        else if (b_we) b_mem[b_waddr] <= b_wdata;
        if (b_we) b_we_cnt <= b_we_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder built from Hamming positions rather than the parity equations.
    function automatic logic [15:0] ref_enc(input logic [15:0] m);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if (k != 1 && k != 2 && k != 4 && k != 8) begin
                c[k] = m[j];
                j++;
            end
        end
        for (int p = 1; p < 16; p = p * 2)
            for (int k = 1; k < 16; k++)
                if ((k & p) != 0 && k != p) c[p] = c[p] ^ c[k];
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic load_a();
        @(negedge clk) a_load = 1'b1;
        @(negedge clk) a_load = 1'b0;
    endtask

    task automatic load_b();
        @(negedge clk) b_load = 1'b1;
        @(negedge clk) b_load = 1'b0;
    endtask

    task automatic run_a(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] exp, input string tag);
        a_init[0]  = lo;
        a_init[1]  = hi;
        a_init[30] = 8'h55;
        a_init[31] = 8'h55;
        load_a();
        @(negedge clk) a_start = 1'b1;
        @(posedge clk);
        @(negedge clk) a_start = 1'b0;
        check_val({tag, " done cleared"}, a_done, 0);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 5) check_val({tag, " done@5"}, a_done, 0);
        end
        check_val({tag, " done@6"}, a_done, 1);
        check_val({tag, " lo byte"}, a_mem[30], exp[7:0]);
        check_val({tag, " hi byte"}, a_mem[31], exp[15:8]);
    endtask

    task automatic fill_b();
        for (int i = 0; i < 30; i++) b_init[i] = 8'($urandom);
        for (int i = 30; i < 60; i++) b_init[i] = 8'hA5;
        load_b();
    endtask

    task automatic count_bad(input int first_word, input int last_word, output int bad);
        logic [15:0] e;
        bad = 0;
        for (int w = first_word; w <= last_word; w++) begin
            e = ref_enc({b_init[2*w+1], b_init[2*w]});
            if (b_mem[30+2*w] !== e[7:0])   bad++;
            if (b_mem[31+2*w] !== e[15:8])  bad++;
        end
    endtask

    task automatic stall_on_match(input bit on_read, input string tag);
        int  i;
        bit  seen;
        seen = 0;
        for (i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (b_req && (on_read ? (b_raddr == 8'd1) : (b_waddr == 8'd30))) seen = 1;
        end
        check_val({tag, " state reached"}, seen, 1);
        if (seen) begin
            b_gnt = 1'b0;
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                if (!on_read) check_val({tag, " no we while gnt low"}, b_we, 0);
            end
            if (!on_read) check_val({tag, " no write while gnt low"}, b_mem[30], 8'hA5);
            b_gnt = 1'b1;
        end
    endtask

    task automatic run_b(input bit contend, input string tag);
        int edges;
        int cnt0;
        int bad;
        fill_b();
        cnt0 = b_we_cnt;
        @(negedge clk) b_start = 1'b1;
        @(posedge clk);
        @(negedge clk) b_start = 1'b0;
        fork
            begin
                edges = 0;
                while (!b_done && edges < 300) begin
                    @(posedge clk);
                    edges++;
                    @(negedge clk);
                    b_start = (edges == 20);
                end
                b_start = 1'b0;
            end
            begin
                if (contend) begin
                    stall_on_match(1'b1, {tag, " rd_hi"});
                    stall_on_match(1'b0, {tag, " wr_lo"});
                end
            end
        join
        check_val({tag, " done edge"}, edges, contend ? 82 : 76);
        repeat (3) @(negedge clk);
        check_val({tag, " done held"}, b_done, 1);
        check_val({tag, " busy low"}, b_busy, 0);
        check_val({tag, " we pulses"}, b_we_cnt - cnt0, 30);
        count_bad(0, 14, bad);
        check_val({tag, " bad bytes"}, bad, 0);
    endtask

    task automatic reset_mid_run();
        int  bad;
        bit  seen;
        fill_b();
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (b_req && b_waddr == 8'd34) seen = 1;
        end
        check_val("reset wr_lo word2 reached", seen, 1);
        reset = 1'b1;
        #1;
        check_val("reset outputs zero",
                  {b_busy, b_done, b_req, b_we, b_raddr, b_waddr, b_wdata}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 34; i < 60; i++) if (b_mem[i] !== 8'hA5) bad++;
        check_val("reset no writes after", bad, 0);
        count_bad(0, 1, bad);
        check_val("reset words0-1 intact", bad, 0);
        check_val("reset idle after", {b_busy, b_done}, 0);
    endtask

    initial begin
        reset   = 1'b1;
        a_start = 1'b0; a_gnt = 1'b1; a_load = 1'b0;
        b_start = 1'b0; b_gnt = 1'b1; b_load = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a_init[i] = 8'h00;
            b_init[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("a reset outputs", {a_busy, a_done, a_req, a_we, a_raddr, a_waddr, a_wdata}, 0);
        check_val("b reset outputs", {b_busy, b_done, b_req, b_we, b_raddr, b_waddr, b_wdata}, 0);
        reset = 1'b0;

        run_a(8'h01, 8'h00, 16'h000F, "d=001");
        run_a(8'hFF, 8'h07, 16'hFFFF, "d=7FF");
        run_a(8'h00, 8'hF8, 16'h0000, "upper ignored");
        run_a(8'h00, 8'h04, 16'h8117, "d=400");

        run_b(1'b0, "full");
        run_b(1'b1, "contention");
        reset_mid_run();
        run_b(1'b0, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
